// File: rtl/stream_reduce_pkg.sv
// Shared mode and state encodings for the stream_reduce burst reducer.
package stream_reduce_pkg;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        LAST  = 2'd1,
        SUM   = 2'd2,
        MAX   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_reduce_alu.sv
// Combinational accumulator update for the beats after the first in a burst.
module stream_reduce_alu
    import stream_reduce_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 26
) (
    input  mode_t              mode_q,
    input  logic [ACC_W-1:0]   acc,
    input  logic [DATA_W-1:0]  in_data,
    output logic [ACC_W-1:0]   next_acc
);

    logic [ACC_W-1:0] data_ext;

    assign data_ext = ACC_W'(in_data);

    always_comb begin
        next_acc = acc;
        case (mode_q)
            FIRST:   next_acc = acc;
            LAST:    next_acc = data_ext;
            SUM:     next_acc = acc + data_ext;
            MAX:     next_acc = (data_ext > acc) ? data_ext : acc;
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/stream_reduce.sv
// Reduces a burst of unsigned samples to one result (first/last/sum/max) with a
// valid/ready handshake on both sides.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a burst
//   ACCUM | burst in progress, folding beats into acc
//   HOLD  | result presented; a beat accepted here starts the next burst
module stream_reduce
    import stream_reduce_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  BURST_LEN = 1024,
    localparam int CNT_W     = $clog2(BURST_LEN + 1),
    localparam int ACC_W     = DATA_W + $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_short
);

    state_t            state;
    mode_t             mode_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  alu_acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;
    logic              first_beat;
    logic              last_beat;

    stream_reduce_alu #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_alu (
        .mode_q   (mode_q),
        .acc      (acc),
        .in_data  (in_data),
        .next_acc (alu_acc)
    );

    // In HOLD a new beat is only taken together with the pending result.
    assign in_ready   = (state != HOLD) || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_beat = (state != ACCUM);
    assign acc_nxt    = first_beat ? ACC_W'(in_data) : alu_acc;
    assign cnt_nxt    = first_beat ? CNT_W'(1) : count + CNT_W'(1);
    assign last_beat  = in_last || (cnt_nxt == CNT_W'(BURST_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= FIRST;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_short <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            count <= cnt_nxt;
            if (first_beat) begin
                mode_q <= mode_t'(mode);
            end
            if (last_beat) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_data  <= acc_nxt;
                out_count <= cnt_nxt;
                out_short <= (cnt_nxt < CNT_W'(BURST_LEN));
            end else begin
                state     <= ACCUM;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_count <= '0;
                out_short <= 1'b0;
            end
        end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_short <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_reduce.sv
// Directed bench for stream_reduce with DATA_W=16, BURST_LEN=4.
module tb_stream_reduce;

    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = $clog2(BURST_LEN + 1);
    localparam int ACC_W     = DATA_W + $clog2(BURST_LEN);

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_short;

    int n_checks = 0;
    int n_errors = 0;

    stream_reduce #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_short (out_short)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_result(input string tag, input logic [31:0] d,
                                input logic [31:0] c, input logic s);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data), d);
        check({tag, "_count"}, 32'(out_count), c);
        check({tag, "_short"}, 32'(out_short), 32'(s));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid0"}, 32'(out_valid), 32'd0);
        check({tag, "_data0"},  32'(out_data), 32'd0);
        check({tag, "_count0"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 2'd0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle_cycles(2);
        check_empty("rst_hold");
        check("rst_short", 32'(out_short), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // SUM 1,2,3,4 back-to-back
        beat(16'd1, 1'b0, 2'd2);
        check("sum_mid_valid", 32'(out_valid), 32'd0);
        beat(16'd2, 1'b0, 2'd2);
        beat(16'd3, 1'b0, 2'd2);
        beat(16'd4, 1'b0, 2'd2);
        check_result("sum", 32'd10, 32'd4, 1'b0);
        tick();
        check_empty("sum_after");

        // MAX 5, FFFF, 10 with in_last
        beat(16'h0005, 1'b0, 2'd3);
        beat(16'hFFFF, 1'b0, 2'd3);
        beat(16'h0010, 1'b1, 2'd3);
        check_result("max", 32'h0FFFF, 32'd3, 1'b1);
        tick();
        check_empty("max_after");

        // FIRST with gaps, then backpressure for 5 cycles
        out_ready = 1'b0;
        beat(16'd7, 1'b0, 2'd0);
        idle_cycles(2);
        beat(16'd8, 1'b0, 2'd0);
        idle_cycles(2);
        beat(16'd9, 1'b0, 2'd0);
        idle_cycles(2);
        check("first_gap_valid", 32'(out_valid), 32'd0);
        beat(16'd10, 1'b0, 2'd0);
        in_valid = 1'b1;
        in_data  = 16'h00AA;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("first_hold_ready", 32'(in_ready), 32'd0);
            check_result("first_hold", 32'd7, 32'd4, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("first_release_ready", 32'(in_ready), 32'd1);
        tick();
        check_empty("first_after");

        // LAST, mode change mid-burst ignored
        beat(16'h0001, 1'b0, 2'd1);
        beat(16'h0002, 1'b0, 2'd2);
        beat(16'h0003, 1'b0, 2'd2);
        beat(16'h0042, 1'b0, 2'd2);
        check_result("last", 32'h42, 32'd4, 1'b0);
        tick();

        // Back-to-back: new burst starts on the emitting cycle
        out_ready = 1'b0;
        beat(16'd2, 1'b0, 2'd2);
        beat(16'd2, 1'b1, 2'd2);
        check_result("b2b_old", 32'd4, 32'd2, 1'b1);
        tick();
        check_result("b2b_old_held", 32'd4, 32'd2, 1'b1);
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        beat(16'd5, 1'b0, 2'd2);
        check("b2b_emitted", 32'(out_valid), 32'd0);
        beat(16'd1, 1'b0, 2'd2);
        beat(16'd1, 1'b0, 2'd2);
        beat(16'd1, 1'b0, 2'd2);
        check_result("b2b_new", 32'd8, 32'd4, 1'b0);
        tick();

        // Reset while holding a result clears outputs without a clock edge
        out_ready = 1'b0;
        beat(16'd9, 1'b1, 2'd2);
        check("rst_hold_pre", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_empty("rst_async_hold");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset mid-burst discards the partial sum
        beat(16'd3, 1'b0, 2'd2);
        beat(16'd3, 1'b0, 2'd2);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        beat(16'd1, 1'b0, 2'd2);
        beat(16'd1, 1'b0, 2'd2);
        beat(16'd1, 1'b0, 2'd2);
        beat(16'd1, 1'b0, 2'd2);
        check_result("rst_fresh", 32'd4, 32'd4, 1'b0);
        tick();
        check_empty("rst_fresh_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_reduce.md
STREAM_REDUCE -- requirements
Module: stream_reduce

Interface
REQ-001 SHALL have parameter DATA_W, default 16: input sample width, >=1.
REQ-002 SHALL have parameter BURST_LEN, default 1024: maximum beats per burst, >=1.
REQ-003 SHALL have derived constants CNT_W = clog2(BURST_LEN+1) and ACC_W = DATA_W + clog2(BURST_LEN), with ACC_W = DATA_W when BURST_LEN = 1.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  reduction select: 0 FIRST, 1 LAST, 2 SUM, 3 MAX.
- in_data  in  DATA_W  unsigned sample.
- in_valid  in  1  sample present.
- in_last  in  1  final beat of burst, qualified by in_valid.
- in_ready  out  1  block accepts a beat.
- out_data  out  ACC_W  reduction result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CNT_W  beats in the reported burst.
- out_short  out  1  burst was ended by in_last before BURST_LEN beats.

Function
REQ-005 SHALL accept a beat only on a cycle where in_valid=1 and in_ready=1.
REQ-006 SHALL emit a result only on a cycle where out_valid=1 and out_ready=1.
REQ-007 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-008 IDLE SHALL drive in_ready=1 and out_valid=0.
REQ-009 On a beat accepted in IDLE, the block SHALL:
- latch mode into mode_q;
- load acc with zero-extended in_data;
- set count to 1.
REQ-010 ACCUM SHALL drive in_ready=1 and out_valid=0.
REQ-011 On each beat accepted in ACCUM, the block SHALL increment count by 1 and update acc according to mode_q:
- FIRST: hold acc.
- LAST: acc = in_data.
- SUM: acc = acc + in_data.
- MAX: acc = unsigned max(acc, in_data).
REQ-012 A beat that has in_last=1, or that brings count to BURST_LEN, SHALL move the FSM to HOLD on the next edge.
- This applies in both IDLE and ACCUM.
- Otherwise IDLE SHALL move to ACCUM.
REQ-013 HOLD SHALL drive out_valid=1, out_data=acc, out_count=count and out_short=(count<BURST_LEN).
- out_valid SHALL rise on the cycle after the final beat is accepted, i.e. latency 1.
REQ-014 In HOLD, in_ready SHALL equal out_ready combinationally.
REQ-015 If out_ready=1 in HOLD and in_valid=0, the FSM SHALL go to IDLE.
REQ-016 If out_ready=1 and in_valid=1 in HOLD, the result SHALL be emitted and the beat SHALL start a new burst, with IDLE-entry semantics.
- The new burst SHALL go to ACCUM, or to HOLD if that beat is final.
REQ-017 While out_valid=1 and out_ready=0, out_data, out_count and out_short SHALL remain stable.
REQ-018 Gaps in in_valid during a burst SHALL be tolerated and SHALL NOT abort the burst or alter acc.
REQ-019 A change on mode during a burst SHALL be ignored until the next first beat.
REQ-020 SUM SHALL never overflow, because ACC_W covers BURST_LEN * (2^DATA_W - 1).
REQ-021 When out_valid=0, out_data, out_count and out_short SHALL be 0.
REQ-022 in_last on a beat in HOLD with out_ready=0 SHALL NOT be sampled, because that beat is not accepted.

Reset
REQ-023 rst=1 SHALL asynchronously force:
- the FSM to IDLE;
- acc, count and mode_q to 0;
- out_valid, out_data, out_count and out_short to 0.
REQ-024 Reset asserted mid-burst or in HOLD SHALL discard the partial or pending result.
- The first beat accepted after rst deasserts SHALL start a fresh burst.
REQ-025 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-026 Package stream_reduce_pkg SHALL hold:
- the mode constants FIRST, LAST, SUM, MAX;
- the FSM state encoding.
REQ-027 The acc update SHALL be one combinational sub-module, stream_reduce_alu, with inputs mode_q, acc, in_data and output next_acc.
REQ-028 The FSM, counter and output registers SHALL reside in stream_reduce.

Verification
All scenarios SHALL run with DATA_W=16 and BURST_LEN=4.
REQ-029 SUM scenario:
- Stimulus: mode=2, beats 1, 2, 3, 4 back-to-back, out_ready=1.
- Response: out_valid for 1 cycle after the 4th beat, out_data=10, out_count=4, out_short=0.
REQ-030 MAX scenario:
- Stimulus: mode=3, beats 0x0005, 0xFFFF, 0x0010, with in_last on the 3rd beat.
- Response: out_data=0xFFFF, out_count=3, out_short=1.
REQ-031 FIRST scenario:
- Stimulus: mode=0, beats 7, 8, 9, 10 with 2-cycle in_valid gaps; out_ready held 0 for 5 cycles.
- Response: out_data=7, stable for all 5 cycles, with in_ready=0 throughout.
REQ-032 LAST scenario:
- Stimulus: mode=1 on the first beat, then mode=2 for the rest; beats 0x0001, 0x0002, 0x0003, 0x0042.
- Response: out_data=0x0042.
REQ-033 Back-to-back scenario:
- Stimulus: in HOLD, out_ready=1 and in_valid=1 with data 5 in the same cycle.
- Response: the old result is emitted, and the following SUM burst 5, 1, 1, 1 yields out_data=8, with no idle cycle between bursts.
REQ-034 Reset scenario:
- Stimulus: rst asserted after 2 SUM beats, then deasserted, then SUM beats 1, 1, 1, 1.
- Response: out_valid=0 immediately on rst, and the following burst yields out_data=4, out_count=4.
